// File: rtl/mandelbrot_gen.sv
// mandelbrot_gen: renders a SCREEN_W x SCREEN_H Mandelbrot frame in raster order, one z-iteration per cycle.
// Define MANDELBROT_CLEAR_EN to blank every pixel (colour 0) before the frame is rendered.
module mandelbrot_gen #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int DATA_W   = 16,
   parameter int FRAC     = 12,
   parameter int MAX_ITER = 15,
   parameter int COLOUR_W = 3
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] x_min,
   input  logic signed [DATA_W-1:0] y_min,
   input  logic signed [DATA_W-1:0] step,
   output logic                     done,
   output logic [X_W-1:0]           vga_x,
   output logic [Y_W-1:0]           vga_y,
   output logic [COLOUR_W-1:0]      vga_colour,
   output logic                     vga_plot
);

   localparam int N_W = $clog2(MAX_ITER + 1);
   localparam logic [N_W-1:0] MAX_N = N_W'(MAX_ITER);
   // 4.0 expressed at the squared scale (2*FRAC fractional bits)
   localparam logic [2*DATA_W:0] ESC_LIM =
      {{(2*DATA_W-2*FRAC-2){1'b0}}, 3'b100, {(2*FRAC){1'b0}}};

`ifdef MANDELBROT_CLEAR_EN
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_INIT, S_ITER, S_PLOT, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_PLOT, S_DONE} state_t;
`endif

   state_t r_state, w_next;

   logic signed [DATA_W-1:0] r_xmin, r_step, r_cr, r_ci, r_zr, r_zi;
   logic [X_W-1:0]           r_x;
   logic [Y_W-1:0]           r_y;
   logic [N_W-1:0]           r_n;

   logic signed [2*DATA_W-1:0] w_zr_ext, w_zi_ext, w_zr2, w_zi2, w_zrzi, w_diff;
   logic signed [2*DATA_W:0]   w_pp2;
   logic [2*DATA_W:0]          w_mag;
   logic signed [DATA_W-1:0]   w_zr_sh, w_zi_sh, w_zr_nx, w_zi_nx;
   logic                       w_escape, w_iter_end, w_last_x, w_last_y;

   // Full-precision products; the magnitude gets one extra bit so the sum cannot wrap
   assign w_zr_ext   = {{DATA_W{r_zr[DATA_W-1]}}, r_zr};
   assign w_zi_ext   = {{DATA_W{r_zi[DATA_W-1]}}, r_zi};
   assign w_zr2      = w_zr_ext * w_zr_ext;
   assign w_zi2      = w_zi_ext * w_zi_ext;
   assign w_zrzi     = w_zr_ext * w_zi_ext;
   assign w_mag      = {1'b0, w_zr2} + {1'b0, w_zi2};
   assign w_escape   = w_mag > ESC_LIM;
   assign w_iter_end = w_escape || (r_n == MAX_N);

   assign w_diff  = w_zr2 - w_zi2;
   assign w_pp2   = {w_zrzi, 1'b0};
   assign w_zr_sh = DATA_W'(w_diff >>> FRAC);
   assign w_zi_sh = DATA_W'(w_pp2 >>> FRAC);
   assign w_zr_nx = w_zr_sh + r_cr;
   assign w_zi_nx = w_zi_sh + r_ci;

   assign w_last_x = (r_x == X_W'(SCREEN_W - 1));
   assign w_last_y = (r_y == Y_W'(SCREEN_H - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
`ifdef MANDELBROT_CLEAR_EN
            if (start) w_next = S_CLEAR;
`else
            if (start) w_next = S_INIT;
`endif
         end
`ifdef MANDELBROT_CLEAR_EN
         S_CLEAR: if (w_last_x && w_last_y) w_next = S_INIT;
`endif
         S_INIT:  w_next = S_ITER;
         S_ITER:  if (w_iter_end) w_next = S_PLOT;
         S_PLOT:  w_next = (w_last_x && w_last_y) ? S_DONE : S_INIT;
         S_DONE:  if (!start) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_xmin <= '0;
         r_step <= '0;
         r_cr   <= '0;
         r_ci   <= '0;
         r_zr   <= '0;
         r_zi   <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_n    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_xmin <= x_min;
                  r_step <= step;
                  r_cr   <= x_min;
                  r_ci   <= y_min;
                  r_x    <= '0;
                  r_y    <= '0;
               end
            end
`ifdef MANDELBROT_CLEAR_EN
            // Sweep the coordinates only; c stays at the origin pixel for the render pass
            S_CLEAR: begin
               if (w_last_x) begin
                  r_x <= '0;
                  r_y <= w_last_y ? '0 : r_y + Y_W'(1);
               end else begin
                  r_x <= r_x + X_W'(1);
               end
            end
`endif
            S_INIT: begin
               r_zr <= '0;
               r_zi <= '0;
               r_n  <= '0;
            end
            S_ITER: begin
               if (!w_iter_end) begin
                  r_zr <= w_zr_nx;
                  r_zi <= w_zi_nx;
                  r_n  <= r_n + N_W'(1);
               end
            end
            S_PLOT: begin
               if (!w_last_x) begin
                  r_x  <= r_x + X_W'(1);
                  r_cr <= r_cr + r_step;
               end else begin
                  r_x  <= '0;
                  r_cr <= r_xmin;
                  r_y  <= w_last_y ? '0 : r_y + Y_W'(1);
                  r_ci <= r_ci + r_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign done  = (r_state == S_DONE);
   assign vga_x = r_x;
   assign vga_y = r_y;
`ifdef MANDELBROT_CLEAR_EN
   assign vga_plot = (r_state == S_PLOT) || (r_state == S_CLEAR);
`else
   assign vga_plot = (r_state == S_PLOT);
`endif
   // Points that never escape are drawn black
   assign vga_colour = ((r_state == S_PLOT) && (r_n != MAX_N)) ? COLOUR_W'(r_n) : '0;

endmodule

// File: tb/tb_mandelbrot_gen.sv
// Self-checking bench for mandelbrot_gen on a 4x2 screen; expected colours and per-pixel
// timing come from an integer model of the escape-time iteration.
module tb_mandelbrot_gen;

   localparam int SW = 4;
   localparam int SH = 2;
   localparam int NPIX = SW * SH;
`ifdef MANDELBROT_CLEAR_EN
   localparam int PRE = NPIX;
`else
   localparam int PRE = 0;
`endif

   logic        clk;
   logic        rstn;
   logic        start;
   logic [15:0] x_min, y_min, step;
   logic        done;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;

   int checks = 0;
   int failures = 0;

   mandelbrot_gen #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .x_min(x_min), .y_min(y_min), .step(step),
      .done(done), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Escape-time count for c = cr + i*ci in Q4.12, 16-bit wrapping state
   function automatic int ref_iter(input shortint cr, input shortint ci);
      longint zr, zi, nzr, nzi;
      int n;
      zr = 0;
      zi = 0;
      n = 0;
      while (1) begin
         if ((zr * zr + zi * zi) > (longint'(4) << 24) || n == 15) return n;
         nzr = ((zr * zr - zi * zi) >>> 12) + longint'(cr);
         nzi = ((2 * zr * zi) >>> 12) + longint'(ci);
         zr = longint'(shortint'(nzr));
         zi = longint'(shortint'(nzi));
         n++;
      end
      return n;
   endfunction

   task automatic outputs_zero(input string tag);
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_plot"}, 64'(vga_plot), 64'(0));
      chk({tag, "_x"}, 64'(vga_x), 64'(0));
      chk({tag, "_y"}, 64'(vga_y), 64'(0));
      chk({tag, "_colour"}, 64'(vga_colour), 64'(0));
   endtask

   task automatic run_frame(input logic [15:0] xm, input logic [15:0] ym, input logic [15:0] st);
      int exp_n[NPIX];
      int idx, cyc, last, ec;
      for (int p = 0; p < NPIX; p++)
         exp_n[p] = ref_iter(shortint'(int'(xm) + (p % SW) * int'(st)),
                             shortint'(int'(ym) + (p / SW) * int'(st)));
      @(negedge clk);
      x_min = xm; y_min = ym; step = st; start = 1'b1;
      cyc = 0; last = 0; idx = 0;
`ifdef MANDELBROT_CLEAR_EN
      for (int i = 0; i < NPIX; i++) begin
         @(negedge clk);
         cyc++;
         chk("clear_plot", 64'(vga_plot), 64'(1));
         chk("clear_x", 64'(vga_x), 64'(i % SW));
         chk("clear_y", 64'(vga_y), 64'(i / SW));
         chk("clear_colour", 64'(vga_colour), 64'(0));
      end
      last = cyc;
`endif
      while (idx < NPIX && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (vga_plot) begin
            ec = (exp_n[idx] == 15) ? 0 : (exp_n[idx] & 7);
            chk("plot_x", 64'(vga_x), 64'(idx % SW));
            chk("plot_y", 64'(vga_y), 64'(idx / SW));
            chk("plot_colour", 64'(vga_colour), 64'(ec));
            chk("plot_gap", 64'(cyc - last), 64'(exp_n[idx] + 3));
            last = cyc;
            idx++;
            if (idx == 1) begin
               x_min = 16'($urandom);
               y_min = 16'($urandom);
               step  = 16'($urandom);
            end
         end
      end
      chk("frame_plots", 64'(idx), 64'(NPIX));
      @(negedge clk);
      chk("frame_done", 64'(done), 64'(1));
      chk("frame_no_plot", 64'(vga_plot), 64'(0));
   endtask

   task automatic release_start();
      start = 1'b0;
      @(negedge clk);
      chk("release_done", 64'(done), 64'(0));
   endtask

   initial begin
      int cyc, nplots;
      logic [15:0] rx, ry, rs;
      rstn = 1'b0; start = 1'b1;
      x_min = '0; y_min = '0; step = '0;

      // Held in reset with start asserted
      repeat (3) begin
         @(negedge clk);
         outputs_zero("reset");
      end
      start = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      outputs_zero("idle");

      // c = 0 everywhere: never escapes
      run_frame(16'h0000, 16'h0000, 16'h0000);
      repeat (4) begin
         @(negedge clk);
         chk("hold_done", 64'(done), 64'(1));
         chk("hold_no_plot", 64'(vga_plot), 64'(0));
      end
      release_start();

      // c = 2.0 escapes after two iterations; c = -2.0 sits on the boundary
      run_frame(16'h2000, 16'h0000, 16'h0000);
      release_start();
      run_frame(16'hE000, 16'h0000, 16'h0000);
      release_start();

      // Reset while iterating pixel (2,0)
      @(negedge clk);
      x_min = '0; y_min = '0; step = '0; start = 1'b1;
      cyc = 0; nplots = 0;
      while (nplots < PRE + 2 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (vga_plot) nplots++;
      end
      chk("midrst_reached", 64'(nplots), 64'(PRE + 2));
      repeat (5) @(negedge clk);
      chk("midrst_pre_x", 64'(vga_x), 64'(2));
      chk("midrst_pre_plot", 64'(vga_plot), 64'(0));
      #2 rstn = 1'b0;
      #1 outputs_zero("midrst");
      start = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      // Randomised frames with c kept inside [-2, 2]
      for (int k = 0; k < 4; k++) begin
         rx = 16'(int'($urandom_range(12288)) - 8192);
         ry = 16'(int'($urandom_range(8192)) - 6144);
         rs = 16'($urandom_range(1365));
         run_frame(rx, ry, rs);
         release_start();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
